// File: rtl/ctrl_seq.sv
// ctrl_seq: multi-cycle instruction controller (IDLE/FETCH/DECODE/EXEC/MEM/WB).
// Accepts a 2-bit opcode through a valid/ready handshake and sequences the
// register-bank write, ALU select and data-memory write strobes for it.
// Optional build macro CTRL_SEQ_STATS_EN adds a 16-bit completed-instruction
// counter output (instr_cnt).
module ctrl_seq #(
  parameter int MEM_WAIT = 2
) (
  input  logic       clk,
  input  logic       rst,
  input  logic       run,
  input  logic       instr_valid,
  input  logic [1:0] in,
  output logic       instr_ready,
  output logic       we,
  output logic       dmux,
  output logic       w,
  output logic       r,
  output logic [3:0] aluop,
  output logic       busy,
  output logic       done
`ifdef CTRL_SEQ_STATS_EN
  ,
  output logic [15:0] instr_cnt
`endif
);

  typedef enum logic [2:0] {
    IDLE   = 3'd0,
    FETCH  = 3'd1,
    DECODE = 3'd2,
    EXEC   = 3'd3,
    MEM    = 3'd4,
    WB     = 3'd5
  } state_t;

  localparam logic [1:0] OP_STORE  = 2'b11;
  localparam logic [3:0] WAIT_LOAD = 4'(MEM_WAIT - 1);

  state_t     state;
  state_t     state_nxt;
  logic [1:0] ir;
  logic [3:0] cnt;
  logic [3:0] alu_dec;

  // State register, instruction register and store wait counter
  always_ff @(posedge clk) begin
    if (rst) begin
      state <= IDLE;
      ir    <= 2'b00;
      cnt   <= 4'd0;
    end else begin
      state <= state_nxt;
      if (state == FETCH && instr_valid) begin
        ir <= in;
      end
      if (state == EXEC && ir == OP_STORE) begin
        cnt <= WAIT_LOAD;
      end else if (state == MEM && cnt != 4'd0) begin
        cnt <= cnt - 4'd1;
      end
    end
  end

  // Opcode to ALU operation mapping, only driven out in EXEC and WB
  always_comb begin
    alu_dec = 4'b1111;
    case (ir)
      2'b00:   alu_dec = 4'b0010;
      2'b01:   alu_dec = 4'b0110;
      2'b10:   alu_dec = 4'b0111;
      default: alu_dec = 4'b1111;
    endcase
  end

  // Next-state and Moore-style control outputs
  always_comb begin
    state_nxt   = state;
    instr_ready = 1'b0;
    we          = 1'b0;
    dmux        = 1'b0;
    w           = 1'b0;
    r           = 1'b0;
    aluop       = 4'b1111;
    busy        = 1'b0;
    done        = 1'b0;
    case (state)
      IDLE: begin
        if (run) state_nxt = FETCH;
      end
      FETCH: begin
        instr_ready = 1'b1;
        if (instr_valid)  state_nxt = DECODE;
        else if (!run)    state_nxt = IDLE;
      end
      DECODE: begin
        busy      = 1'b1;
        state_nxt = EXEC;
      end
      EXEC: begin
        busy  = 1'b1;
        aluop = alu_dec;
        dmux  = (ir == OP_STORE);
        if (ir == OP_STORE) state_nxt = MEM;
        else                state_nxt = WB;
      end
      MEM: begin
        busy = 1'b1;
        w    = 1'b1;
        dmux = 1'b1;
        if (cnt == 4'd0) begin
          done      = 1'b1;
          state_nxt = FETCH;
        end
      end
      WB: begin
        busy      = 1'b1;
        we        = 1'b1;
        aluop     = alu_dec;
        done      = 1'b1;
        state_nxt = FETCH;
      end
      default: begin
        state_nxt = IDLE;
      end
    endcase
  end

`ifdef CTRL_SEQ_STATS_EN
  // Count completed instructions, wrapping at 16 bits
  always_ff @(posedge clk) begin
    if (rst) begin
      instr_cnt <= 16'd0;
    end else if (done) begin
      instr_cnt <= instr_cnt + 16'd1;
    end
  end
`endif

endmodule

// File: tb/tb_ctrl_seq.sv
// tb_ctrl_seq: scoreboard bench for ctrl_seq built with MEM_WAIT=3.
// Stimulus pushes the expected completion record of each accepted opcode;
// a negedge monitor pops and compares it whenever done pulses.
module tb_ctrl_seq;

  localparam int MEM_WAIT = 3;

  logic       clk;
  logic       rst;
  logic       run;
  logic       instr_valid;
  logic [1:0] in_op;
  logic       instr_ready;
  logic       we;
  logic       dmux;
  logic       w;
  logic       r;
  logic [3:0] aluop;
  logic       busy;
  logic       done;
`ifdef CTRL_SEQ_STATS_EN
  logic [15:0] instr_cnt;
`endif

  int errors = 0;
  int checks = 0;

  typedef struct {
    logic [3:0] aluop;
    logic       dmux;
    logic       we;
    int         wcyc;
    int         wecyc;
    int         lat;
  } exp_t;

  exp_t sb_q[$];

  ctrl_seq #(.MEM_WAIT(MEM_WAIT)) dut (
    .clk         (clk),
    .rst         (rst),
    .run         (run),
    .instr_valid (instr_valid),
    .in          (in_op),
    .instr_ready (instr_ready),
    .we          (we),
    .dmux        (dmux),
    .w           (w),
    .r           (r),
    .aluop       (aluop),
    .busy        (busy),
    .done        (done)
`ifdef CTRL_SEQ_STATS_EN
    ,
    .instr_cnt   (instr_cnt)
`endif
  );

  // Free-running clock
  initial clk = 1'b0;
  always #5 clk = ~clk;

  task automatic checkOutput(input string name, input logic [15:0] actual, input logic [15:0] expected);
    checks++;
    if (actual !== expected) begin
      errors++;
      $display("[TB] FAIL %s: got %0h expected %0h", name, actual, expected);
    end
  endtask

  task automatic applyStimulus(input logic rst_v, input logic run_v, input logic valid_v, input logic [1:0] op_v);
    rst         = rst_v;
    run         = run_v;
    instr_valid = valid_v;
    in_op       = op_v;
  endtask

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  // Hand-computed completion records; arithmetic done 3 cycles after the
  // handshake cycle, store done 2+MEM_WAIT = 5 cycles after it
  task automatic pushExpect(input logic [1:0] op);
    exp_t e;
    case (op)
      2'b00:   e = '{aluop: 4'b0010, dmux: 1'b0, we: 1'b1, wcyc: 0, wecyc: 1, lat: 3};
      2'b01:   e = '{aluop: 4'b0110, dmux: 1'b0, we: 1'b1, wcyc: 0, wecyc: 1, lat: 3};
      2'b10:   e = '{aluop: 4'b0111, dmux: 1'b0, we: 1'b1, wcyc: 0, wecyc: 1, lat: 3};
      default: e = '{aluop: 4'b1111, dmux: 1'b1, we: 1'b0, wcyc: 3, wecyc: 0, lat: 5};
    endcase
    sb_q.push_back(e);
  endtask

  task automatic checkResetOutputs(input string tag);
    checkOutput({tag, "_ready"}, 16'(instr_ready), 16'h0);
    checkOutput({tag, "_we"},    16'(we),          16'h0);
    checkOutput({tag, "_dmux"},  16'(dmux),        16'h0);
    checkOutput({tag, "_w"},     16'(w),           16'h0);
    checkOutput({tag, "_r"},     16'(r),           16'h0);
    checkOutput({tag, "_aluop"}, 16'(aluop),       16'hf);
    checkOutput({tag, "_busy"},  16'(busy),        16'h0);
    checkOutput({tag, "_done"},  16'(done),        16'h0);
  endtask

  // Monitor: track handshakes and strobes, compare against scoreboard on done
  int cycle   = 0;
  int hs_cyc  = 0;
  int wcnt    = 0;
  int wecnt   = 0;
  always @(negedge clk) begin
    exp_t e;
    if (rst) begin
      wcnt  = 0;
      wecnt = 0;
    end else begin
      if (w)  wcnt++;
      if (we) wecnt++;
      if (instr_ready && instr_valid) hs_cyc = cycle;
      if (done) begin
        if (sb_q.size() == 0) begin
          checks++;
          errors++;
          $display("[TB] FAIL sb_unexpected_done: got done=1 expected no pending instruction");
        end else begin
          e = sb_q.pop_front();
          checkOutput("sb_aluop",   16'(aluop),          16'(e.aluop));
          checkOutput("sb_dmux",    16'(dmux),           16'(e.dmux));
          checkOutput("sb_we",      16'(we),             16'(e.we));
          checkOutput("sb_r",       16'(r),              16'h0);
          checkOutput("sb_wcycles", 16'(wcnt),           16'(e.wcyc));
          checkOutput("sb_wecycles",16'(wecnt),          16'(e.wecyc));
          checkOutput("sb_latency", 16'(cycle - hs_cyc), 16'(e.lat));
        end
        wcnt  = 0;
        wecnt = 0;
      end
    end
    cycle++;
  end

  // Directed stimulus with inline cycle-accurate checks
  initial begin
    applyStimulus(1'b1, 1'b0, 1'b0, 2'b00);
    tick();
    tick();
    checkResetOutputs("reset");
`ifdef CTRL_SEQ_STATS_EN
    checkOutput("reset_instr_cnt", instr_cnt, 16'h0);
`endif

    // Add: IDLE -> FETCH -> DECODE -> EXEC -> WB -> FETCH
    applyStimulus(1'b0, 1'b1, 1'b0, 2'b00);
    tick();
    checkOutput("add_fetch_ready", 16'(instr_ready), 16'h1);
    checkOutput("add_fetch_busy",  16'(busy),        16'h0);
    applyStimulus(1'b0, 1'b1, 1'b1, 2'b00);
    pushExpect(2'b00);
    tick();
    applyStimulus(1'b0, 1'b1, 1'b0, 2'b00);
    checkOutput("add_decode_ready", 16'(instr_ready), 16'h0);
    checkOutput("add_decode_busy",  16'(busy),        16'h1);
    checkOutput("add_decode_aluop", 16'(aluop),       16'hf);
    tick();
    checkOutput("add_exec_aluop", 16'(aluop), 16'h2);
    checkOutput("add_exec_we",    16'(we),    16'h0);
    checkOutput("add_exec_done",  16'(done),  16'h0);
    tick();
    checkOutput("add_wb_we",    16'(we),    16'h1);
    checkOutput("add_wb_done",  16'(done),  16'h1);
    checkOutput("add_wb_aluop", 16'(aluop), 16'h2);
    checkOutput("add_wb_dmux",  16'(dmux),  16'h0);
    tick();
    checkOutput("add_ready_again", 16'(instr_ready), 16'h1);

    // Store with MEM_WAIT=3
    applyStimulus(1'b0, 1'b1, 1'b1, 2'b11);
    pushExpect(2'b11);
    tick();
    applyStimulus(1'b0, 1'b1, 1'b0, 2'b00);
    tick();
    checkOutput("st_exec_dmux",  16'(dmux),  16'h1);
    checkOutput("st_exec_aluop", 16'(aluop), 16'hf);
    checkOutput("st_exec_w",     16'(w),     16'h0);
    for (int i = 0; i < 3; i++) begin
      tick();
      checkOutput("st_mem_w",     16'(w),     16'h1);
      checkOutput("st_mem_dmux",  16'(dmux),  16'h1);
      checkOutput("st_mem_we",    16'(we),    16'h0);
      checkOutput("st_mem_aluop", 16'(aluop), 16'hf);
      checkOutput("st_mem_done",  16'(done),  (i == 2) ? 16'h1 : 16'h0);
    end
    tick();
    checkOutput("st_ready_again", 16'(instr_ready), 16'h1);
    checkOutput("st_after_w",     16'(w),           16'h0);

    // Back-to-back sub then ternary with valid held high; IR must hold in EXEC
    applyStimulus(1'b0, 1'b1, 1'b1, 2'b01);
    pushExpect(2'b01);
    tick();
    applyStimulus(1'b0, 1'b1, 1'b1, 2'b10);
    pushExpect(2'b10);
    tick();
    checkOutput("b2b_exec1_aluop", 16'(aluop), 16'h6);
    tick();
    checkOutput("b2b_wb1_done",  16'(done),  16'h1);
    checkOutput("b2b_wb1_aluop", 16'(aluop), 16'h6);
    tick();
    checkOutput("b2b_fetch_ready", 16'(instr_ready), 16'h1);
    tick();
    applyStimulus(1'b0, 1'b1, 1'b0, 2'b00);
    tick();
    checkOutput("b2b_exec2_aluop", 16'(aluop), 16'h7);
    tick();
    checkOutput("b2b_wb2_done",  16'(done),  16'h1);
    checkOutput("b2b_wb2_aluop", 16'(aluop), 16'h7);
    tick();

    // Store aborted by reset in its second MEM cycle
    applyStimulus(1'b0, 1'b1, 1'b1, 2'b11);
    tick();
    applyStimulus(1'b0, 1'b1, 1'b0, 2'b00);
    tick();
    tick();
    tick();
    checkOutput("abort_mem2_w", 16'(w), 16'h1);
    applyStimulus(1'b1, 1'b1, 1'b0, 2'b00);
    tick();
    checkResetOutputs("abort");
`ifdef CTRL_SEQ_STATS_EN
    checkOutput("abort_instr_cnt", instr_cnt, 16'h0);
`endif
    applyStimulus(1'b0, 1'b1, 1'b0, 2'b00);
    tick();
    checkOutput("abort_refetch_ready", 16'(instr_ready), 16'h1);

    // Run dropped during EXEC: WB completes, one FETCH, then IDLE
    applyStimulus(1'b0, 1'b1, 1'b1, 2'b00);
    pushExpect(2'b00);
    tick();
    applyStimulus(1'b0, 1'b1, 1'b0, 2'b00);
    tick();
    applyStimulus(1'b0, 1'b0, 1'b0, 2'b00);
    tick();
    checkOutput("rundrop_wb_we",   16'(we),   16'h1);
    checkOutput("rundrop_wb_done", 16'(done), 16'h1);
    tick();
    checkOutput("rundrop_fetch_ready", 16'(instr_ready), 16'h1);
    tick();
    checkOutput("rundrop_idle_ready", 16'(instr_ready), 16'h0);
    applyStimulus(1'b0, 1'b0, 1'b1, 2'b00);
    tick();
    checkOutput("rundrop_ignored_ready", 16'(instr_ready), 16'h0);
    tick();
    checkOutput("rundrop_ignored_busy", 16'(busy), 16'h0);
`ifdef CTRL_SEQ_STATS_EN
    checkOutput("rundrop_instr_cnt", instr_cnt, 16'h1);
`endif

    // Reset dominates run and valid in a FETCH cycle
    applyStimulus(1'b0, 1'b1, 1'b0, 2'b00);
    tick();
    applyStimulus(1'b1, 1'b1, 1'b1, 2'b01);
    tick();
    checkOutput("dom_ready", 16'(instr_ready), 16'h0);
    checkOutput("dom_busy",  16'(busy),        16'h0);
    applyStimulus(1'b0, 1'b0, 1'b0, 2'b00);
    tick();
    tick();
    checkOutput("dom_idle_busy", 16'(busy), 16'h0);

    checkOutput("scoreboard_drained", 16'(sb_q.size()), 16'h0);

    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule
